// File: rtl/shift_serializer_tx.sv
// Parallel-in, serial-out transmitter with a valid/ready word interface.
// Bit order is latched per word; an optional idle gap separates consecutive words.
module shift_serializer_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             lsb_first,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             order;
  logic             word_end;
  logic             xfer;

  assign word_end = (state == SHIFT) && (bit_cnt == LAST_IDX);
  assign xfer     = data_valid && data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (word_end) begin
          if (xfer)                 state_nxt = SHIFT;
          else if (GAP_CYCLES > 0)  state_nxt = GAP;
          else                      state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on transfer, otherwise shift toward the selected output end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      order   <= 1'b0;
    end else if (enable) begin
      if (xfer) begin
        shreg   <= data_in;
        order   <= lsb_first;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= order ? (shreg >> 1) : (shreg << 1);
        bit_cnt <= word_end ? '0 : bit_cnt + CNT_W'(1);
      end
      if (state == GAP) begin
        gap_cnt <= (gap_cnt == GAP_LAST) ? 4'd0 : gap_cnt + 4'd1;
      end else begin
        gap_cnt <= 4'd0;
      end
    end
  end

  // Outputs decode registered state only; data_in never reaches serial_out directly
  always_comb begin
    serial_out = 1'b0;
    frame      = 1'b0;
    first_bit  = 1'b0;
    last_bit   = 1'b0;
    busy       = 1'b0;
    case (state)
      SHIFT: begin
        serial_out = order ? shreg[0] : shreg[WIDTH-1];
        frame      = 1'b1;
        first_bit  = (bit_cnt == '0);
        last_bit   = word_end;
        busy       = 1'b1;
      end
      GAP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    data_ready = enable && ((state == IDLE) || ((GAP_CYCLES == 0) && word_end));
  end

endmodule

// File: doc/shift_serializer_tx.md
Name: shift_serializer_tx

Overview:
Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB-first or LSB-first. It is the driving end for the universal_shift_register serial inputs: its serial_out feeds serial_in_right or serial_in_left, and its frame strobe gates the receiver's enable. An optional idle gap separates consecutive words.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
GAP_CYCLES, 1, idle cycles inserted after each word; legal range is 0..15.

Ports:
clk  input  1  clock; all flops update on the rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  clock enable; when 0 all state holds.
lsb_first  input  1  bit order for the word being accepted: 1 = LSB first, 0 = MSB first.
data_in  input  WIDTH  word to transmit.
data_valid  input  1  data_in is valid.
data_ready  output  1  block can accept a word this cycle.
serial_out  output  1  serial bit stream.
frame  output  1  high while a data bit is on serial_out.
first_bit  output  1  high during bit 0 of a word.
last_bit  output  1  high during bit WIDTH-1 of a word.
busy  output  1  high when the state is not IDLE.

Behaviour:
- States:
  - IDLE: waiting for a word.
  - SHIFT: driving bits; bit_cnt runs 0..WIDTH-1.
  - GAP: idle spacing; gap_cnt runs 0..GAP_CYCLES-1.
- Reset (async, rst_n=0):
  - state=IDLE, shift register=0, bit_cnt=0, gap_cnt=0, latched order=0.
  - serial_out=0, frame=0, first_bit=0, last_bit=0, busy=0.
  - data_ready=enable. Words presented while rst_n=0 are not accepted.
- data_ready = enable AND (state==IDLE OR (GAP_CYCLES==0 AND state==SHIFT AND last_bit)).
- Transfer occurs on a rising edge with data_valid=1, data_ready=1 and rst_n=1.
  - On that edge: load data_in, latch lsb_first, set bit_cnt=0, enter SHIFT.
  - data_in and lsb_first are ignored at all other times.
- Latency: the first bit appears on serial_out in the cycle immediately after the transfer edge.
- SHIFT:
  - serial_out = shreg[WIDTH-1] when the latched order is MSB-first, shreg[0] when LSB-first.
  - Each enabled edge shifts the register toward the output end with 0 fill and increments bit_cnt.
  - frame=1. first_bit=(bit_cnt==0). last_bit=(bit_cnt==WIDTH-1).
- End of word: the enabled edge taken with last_bit=1 moves to:
  - SHIFT with the new word, if a transfer occurs on that edge (only possible when GAP_CYCLES==0; gives zero dead cycles);
  - GAP, if GAP_CYCLES>0;
  - IDLE, otherwise.
- GAP: serial_out=0, frame=0, busy=1. After GAP_CYCLES enabled edges, enter IDLE.
- IDLE: serial_out=0, frame=0, busy=0.
- Outputs are decoded only from flops (state, shreg, counters); there is no combinational path from data_in to serial_out.
- enable=0: state, counters and the shift register hold, and the outputs keep their current values. A bit whose enable was low is extended; it is not dropped. data_ready=0.
- Reset mid-word: outputs clear immediately, the partial word is discarded, and after release the block is in IDLE.
- data_valid with data_ready=0: no effect. The upstream holds data_valid until the transfer completes.

Test Plan:
- WIDTH=8, GAP_CYCLES=1; reset, then send 0xA5 MSB-first.
  -> serial_out = 1,0,1,0,0,1,0,1 on the 8 cycles after the transfer edge.
  -> frame high for 8 cycles; first_bit in cycle 1 only; last_bit in cycle 8 only.
  -> data_ready low for 9 cycles, high again on the 10th.
- Send 0xA5 with lsb_first=1.
  -> serial_out = 1,0,1,0,0,1,0,1 (palindrome check).
  -> then 0x01 LSB-first gives 1,0,0,0,0,0,0,0; MSB-first gives 0,0,0,0,0,0,0,1.
- GAP_CYCLES=0, data_valid held high with 0xFF then 0x00.
  -> 16 consecutive frame=1 cycles, 8 ones then 8 zeros.
  -> data_ready high on the last_bit cycle; no dead cycle between words.
- Deassert enable for 3 cycles during bit 3 of 0xF0 (MSB-first).
  -> bit 3 (value 1) is held for 4 cycles, followed by the remaining 0,0,0,0; total frame cycles = 11.
- Assert rst_n=0 mid-word (bit 5).
  -> serial_out and frame go to 0 with no clock edge.
  -> after release, busy=0 and data_ready=1; the next word 0x3C transmits cleanly.
- Loopback: drive universal_shift_register (WIDTH=8) with mode=01, serial_in_right=serial_out, enable=frame.
  -> after each LSB-first word its q equals the sent word, for 100 random words.
